// File: rtl/fnd_pkg.sv
// Shared types and the seven-segment decoder for the FND counter.
// Segment encoding is active-low {g,f,e,d,c,b,a}.
package fnd_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Non-BCD codes cannot occur, but they still decode to blank so the pins stay dark.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One up/down BCD digit.
// o_co flags that this digit rolls over (9->0 or 0->9) on the current enable.
module bcd_digit
   import fnd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_en,
   input  logic       i_dir,
   input  logic       i_clr,
   output logic [3:0] o_q,
   output logic       o_co
);

   assign o_co = i_en & (i_dir ? (o_q == 4'd0) : (o_q == 4'd9));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         o_q <= 4'd0;
      else if (i_clr)
         o_q <= 4'd0;
      else if (i_en) begin
         if (i_dir)
            o_q <= (o_q == 4'd0) ? 4'd9 : o_q - 4'd1;
         else
            o_q <= (o_q == 4'd9) ? 4'd0 : o_q + 4'd1;
      end
   end

endmodule

// File: rtl/bcd_counter_fnd.sv
// N-digit BCD up/down counter with run/stop mode, single-step and wrap pulse,
// driving a multiplexed active-low seven-segment display.
module bcd_counter_fnd
   import fnd_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int DIV_COUNT  = 10_000_000,
   parameter int DIV_SCAN   = 10_000,
   parameter int BLANK_LZ   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_run,
   input  logic                    i_clr,
   input  logic                    i_dir,
   input  logic                    i_step,
   output logic [4*NUM_DIGITS-1:0] o_count_bcd,
   output logic                    o_wrap,
   output logic [NUM_DIGITS-1:0]   o_fnd_com,
   output logic [6:0]              o_fnd_data
);

   localparam int DCW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
   localparam int DSW = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
   localparam int IW  = $clog2(NUM_DIGITS);

   logic r_run_s1, r_run_s2, r_clr_s1, r_clr_s2, r_dir_s1, r_dir_s2;
   logic r_step_s1, r_step_s2, r_step_s3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {r_run_s1, r_run_s2, r_clr_s1, r_clr_s2, r_dir_s1, r_dir_s2} <= '0;
         {r_step_s1, r_step_s2, r_step_s3} <= '0;
      end else begin
         {r_run_s2, r_run_s1}   <= {r_run_s1, i_run};
         {r_clr_s2, r_clr_s1}   <= {r_clr_s1, i_clr};
         {r_dir_s2, r_dir_s1}   <= {r_dir_s1, i_dir};
         {r_step_s3, r_step_s2, r_step_s1} <= {r_step_s2, r_step_s1, i_step};
      end
   end

   state_t           r_state;
   logic [DCW-1:0]   r_cdiv;
   logic             w_tick, w_adv;

   assign w_tick = (r_state == ST_RUN) && (r_cdiv == DCW'(DIV_COUNT - 1));
   assign w_adv  = w_tick | ((r_state == ST_STOP) & r_step_s2 & ~r_step_s3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_STOP;
         r_cdiv  <= '0;
      end else begin
         case (r_state)
            ST_STOP: begin
               r_cdiv <= '0;
               if (r_run_s2) r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (!r_run_s2) begin
                  r_state <= ST_STOP;
                  r_cdiv  <= '0;
               end else if (w_tick)
                  r_cdiv <= '0;
               else
                  r_cdiv <= r_cdiv + 1'b1;
            end
            default: r_state <= ST_STOP;
         endcase
      end
   end

   logic [NUM_DIGITS-1:0][3:0] w_cnt;
   logic [NUM_DIGITS-1:0]      w_co_all;

   // Ripple chain: each digit is enabled by the rollover of the one below it.
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
      logic w_ci, w_co;
      if (g == 0) begin : g_first
         assign w_ci = w_adv;
      end else begin : g_rest
         assign w_ci = g_dig[g-1].w_co;
      end
      assign w_co_all[g] = w_co;
      bcd_digit u_dig (
         .clk   (clk),
         .rst   (rst),
         .i_en  (w_ci),
         .i_dir (r_dir_s2),
         .i_clr (r_clr_s2),
         .o_q   (w_cnt[g]),
         .o_co  (w_co)
      );
   end

   logic r_wrap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_wrap <= 1'b0;
      else
         r_wrap <= r_clr_s2 ? 1'b0 : &w_co_all;
   end

   assign o_count_bcd = w_cnt;
   assign o_wrap      = r_wrap;

   logic [DSW-1:0] r_sdiv;
   logic [IW-1:0]  r_idx;
   logic [3:0]     w_nib;
   logic           w_lz, w_blank;

   assign w_nib = w_cnt[r_idx];

   // Leading zero: this digit and everything above it are zero.
   always_comb begin
      w_lz = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (i >= int'(r_idx) && w_cnt[i] != 4'd0) w_lz = 1'b0;
      w_blank = (BLANK_LZ != 0) && (r_idx != '0) && w_lz;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sdiv     <= '0;
         r_idx      <= '0;
         o_fnd_com  <= '1;
         o_fnd_data <= SEG_BLANK;
      end else begin
         if (r_sdiv == DSW'(DIV_SCAN - 1)) begin
            r_sdiv <= '0;
            r_idx  <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
         end else
            r_sdiv <= r_sdiv + 1'b1;
         o_fnd_com  <= ~(NUM_DIGITS'(1) << r_idx);
         o_fnd_data <= w_blank ? SEG_BLANK : seg_decode(w_nib);
      end
   end

endmodule

// File: tb/tb_bcd_counter_fnd.sv
// Scoreboard bench: stimulus pushes predicted count events (value, wrap, edge
// number) from an integer model; a negedge monitor pops on every count change.
module tb_bcd_counter_fnd;

   localparam int N  = 4;
   localparam int DC = 4;
   localparam int DS = 2;

   logic           clk = 1'b0, rst = 1'b1;
   logic           i_run = 1'b0, i_clr = 1'b0, i_dir = 1'b0, i_step = 1'b0;
   logic [4*N-1:0] o_count_bcd;
   logic           o_wrap;
   logic [N-1:0]   o_fnd_com;
   logic [6:0]     o_fnd_data;

   bcd_counter_fnd #(.NUM_DIGITS(N), .DIV_COUNT(DC), .DIV_SCAN(DS), .BLANK_LZ(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_run       (i_run),
      .i_clr       (i_clr),
      .i_dir       (i_dir),
      .i_step      (i_step),
      .o_count_bcd (o_count_bcd),
      .o_wrap      (o_wrap),
      .o_fnd_com   (o_fnd_com),
      .o_fnd_data  (o_fnd_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] cnt;
      logic        wrap;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   exp_t        m_e;
   int          cyc = 0, n_cmp = 0, n_bad = 0, n_push = 0, n_pop = 0;
   int          v = 0, t_next = 0;
   bit          mon_en = 1'b0;
   logic [15:0] prev = '0;
   logic [6:0]  seg_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   always @(posedge clk) cyc++;

   function automatic logic [15:0] to_bcd(input int x);
      logic [15:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'((x / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (mon_en && (o_count_bcd !== prev || o_wrap !== 1'b0)) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: count=%h wrap=%b cycle=%0d, no change expected",
                     o_count_bcd, o_wrap, cyc);
         end else begin
            m_e = q.pop_front();
            n_pop++;
            if (o_count_bcd !== m_e.cnt || o_wrap !== m_e.wrap || cyc != m_e.cyc) begin
               n_bad++;
               $display("FAIL count_event: got count=%h wrap=%b cycle=%0d, want count=%h wrap=%b cycle=%0d",
                        o_count_bcd, o_wrap, cyc, m_e.cnt, m_e.wrap, m_e.cyc);
            end
         end
      end
      prev = o_count_bcd;
   end

   task automatic summary_and_finish();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   endtask

   task automatic push_exp(input logic [15:0] c, input logic w, input int t);
      exp_t e;
      e.cnt  = c;
      e.wrap = w;
      e.cyc  = t;
      q.push_back(e);
      n_push++;
   endtask

   task automatic model_adv(input bit d, output logic w);
      if (!d) begin
         w = (v == 9999);
         v = (v + 1) % 10000;
      end else begin
         w = (v == 0);
         v = (v + 9999) % 10000;
      end
   endtask

   task automatic drain();
      int dl;
      dl = cyc + (n_push - n_pop) * DC + 40;
      while (n_pop != n_push && cyc < dl) @(n_pop or cyc);
      if (n_pop != n_push) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: %0d events outstanding, want 0", n_push - n_pop);
         summary_and_finish();
      end
   endtask

   task automatic run_start(input bit d);
      @(negedge clk);
      i_dir  = d;
      i_run  = 1'b1;
      t_next = cyc + 3 + DC;
   endtask

   task automatic adv();
      logic w;
      model_adv(i_dir, w);
      push_exp(to_bcd(v), w, t_next);
      t_next += DC;
   endtask

   task automatic run_stop();
      i_run = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic run_n(input int n, input bit d);
      run_start(d);
      repeat (n) adv();
      drain();
      run_stop();
   endtask

   task automatic step_pulse(input bit expect_adv);
      logic w;
      @(negedge clk);
      i_step = 1'b1;
      if (expect_adv) begin
         model_adv(i_dir, w);
         push_exp(to_bcd(v), w, cyc + 3);
      end
      repeat (2) @(negedge clk);
      i_step = 1'b0;
      repeat ($urandom_range(2, 5)) @(negedge clk);
   endtask

   task automatic clr_pulse();
      @(negedge clk);
      i_clr = 1'b1;
      if (v != 0) push_exp(16'h0000, 1'b0, cyc + 3);
      v = 0;
      @(negedge clk);
      i_clr = 1'b0;
      repeat (4) @(negedge clk);
      drain();
   endtask

   task automatic check_disp(input string nm, input logic [N-1:0] c, input logic [6:0] d);
      n_cmp++;
      if (o_fnd_com !== c || o_fnd_data !== d) begin
         n_bad++;
         $display("FAIL %s: got com=%b data=%h, want com=%b data=%h", nm, o_fnd_com, o_fnd_data, c, d);
      end
   endtask

   task automatic check_reset_state(input string nm);
      n_cmp++;
      if (o_count_bcd !== 16'h0000 || o_wrap !== 1'b0 || o_fnd_com !== 4'b1111 || o_fnd_data !== 7'h7F) begin
         n_bad++;
         $display("FAIL %s: got count=%h wrap=%b com=%b data=%h, want 0000 0 1111 7f",
                  nm, o_count_bcd, o_wrap, o_fnd_com, o_fnd_data);
      end
   endtask

   // Expected display derived from the model value: digit i blanks when i>0 and v < 10^i.
   task automatic scan_chk(input int ncyc);
      int          idx, dl, p, dig;
      logic [N-1:0] pc, ec;
      logic [6:0]  ed;
      dl = cyc + 40;
      @(negedge clk);
      while (o_fnd_com !== 4'b1110 && cyc < dl) @(negedge clk);
      n_cmp++;
      if (o_fnd_com !== 4'b1110) begin
         n_bad++;
         $display("FAIL scan_sync: got com=%b, want 1110 within 40 cycles", o_fnd_com);
      end
      idx = 0;
      pc  = o_fnd_com;
      repeat (ncyc) begin
         if (o_fnd_com !== pc) idx = (idx + 1) % N;
         p = 1;
         for (int i = 0; i < idx; i++) p = p * 10;
         dig = (v / p) % 10;
         ec  = ~(N'(1) << idx);
         ed  = (idx > 0 && v < p) ? 7'h7F : seg_ref[dig];
         check_disp("scan", ec, ed);
         pc = o_fnd_com;
         @(negedge clk);
      end
   endtask

   initial begin
      #1_000_000;
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      summary_and_finish();
   end

   initial begin
      // Reset state and first display after release.
      @(negedge clk);
      check_reset_state("reset_initial");
      rst = 1'b0;
      @(negedge clk);
      check_disp("post_reset_idx0", 4'b1110, 7'h40);
      mon_en = 1'b1;
      scan_chk(12);

      // Reset asserted asynchronously mid-run at 0123.
      run_start(1'b0);
      repeat (123) adv();
      drain();
      #2;
      mon_en = 1'b0;
      rst    = 1'b1;
      #1;
      check_reset_state("reset_async_mid_run");
      i_run = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state("reset_held");
      rst = 1'b0;
      v   = 0;
      @(negedge clk);
      check_disp("post_reset_release", 4'b1110, 7'h40);
      mon_en = 1'b1;

      // Up count through 0998 -> 0999 -> 1000 (three-digit ripple).
      run_n(1000, 1'b0);
      clr_pulse();

      // Wraps in both directions, dir changed mid-run.
      run_start(1'b1);
      adv();
      drain();
      i_dir = 1'b0;
      adv();
      drain();
      i_dir = 1'b1;
      adv();
      drain();
      run_stop();

      // Single steps in STOP from 0041.
      clr_pulse();
      run_n(41, 1'b0);
      repeat (3) step_pulse(1'b1);
      drain();

      // Step edges in RUN are ignored.
      run_start(1'b0);
      repeat (8) adv();
      repeat (3) step_pulse(1'b0);
      drain();
      run_stop();

      // Randomised runs and steps with direction changes.
      for (int r = 0; r < 6; r++) begin
         run_start(1'($urandom_range(0, 1)));
         repeat ($urandom_range(1, 12)) begin
            adv();
            drain();
            if ($urandom_range(0, 2) == 0) i_dir = ~i_dir;
         end
         run_stop();
         i_dir = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 3)) step_pulse(1'b1);
         drain();
      end

      // clr lands on the same edge as a tick at 0507.
      clr_pulse();
      run_start(1'b0);
      repeat (507) adv();
      drain();
      @(negedge clk);
      i_clr = 1'b1;
      push_exp(16'h0000, 1'b0, cyc + 3);
      v = 0;
      t_next += DC;
      @(negedge clk);
      i_clr = 1'b0;
      adv();
      drain();
      run_stop();

      // Display scan at 0042.
      clr_pulse();
      run_n(42, 1'b0);
      scan_chk(16);

      repeat (4) @(negedge clk);
      summary_and_finish();
   end

endmodule

// File: doc/bcd_counter_fnd.md
# bcd_counter_fnd

Parametrised N-digit BCD up/down counter with multiplexed seven-segment drive. It is the next generation of the 4-digit counter: digit count, tick rates and leading-zero blanking are parameters. It adds synchronised control inputs, a run/stop mode FSM, single-step advance, and a wrap pulse. The block sits between board switches and buttons and the FND pins, and also exports the BCD value to other logic.

## Interface
- NUM_DIGITS, 4, number of BCD digits and FND commons (2..8)
- DIV_COUNT, 10_000_000, clk cycles per count tick in RUN
- DIV_SCAN, 10_000, clk cycles per display-scan step
- BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 never blanked)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- run  in  1  level; 1 = RUN mode, 0 = STOP mode
- clr  in  1  level; synchronous clear of count
- dir  in  1  0 = count up, 1 = count down
- step  in  1  button; each rising edge advances by one while in STOP
- count_bcd  out  4*NUM_DIGITS  BCD value; nibble 0 = least significant digit
- wrap  out  1  one-clk pulse when the count wraps
- fnd_com  out  NUM_DIGITS  active-low digit enables; bit i = digit i
- fnd_data  out  7  active-low segments {g,f,e,d,c,b,a}

## Operation
- Input conditioning: run, clr, dir and step each pass through a 2-FF synchroniser. step additionally uses a third FF for rising-edge detection. Only synchronised versions are used internally.
- Mode FSM:
  - States: STOP (reset state) and RUN.
  - Transitions: STOP→RUN when run_s=1; RUN→STOP when run_s=0.
  - The count divider is held at 0 in STOP. In RUN it counts 0..DIV_COUNT-1; tick=1 when divider==DIV_COUNT-1.
- Advance event: (RUN & tick) | (STOP & step rising edge). A step edge in RUN is ignored.
- Up count: digit 0 increments. Any digit going 9→0 carries into the next digit. All 9s → all 0s, with wrap=1 on that cycle.
- Down count: digit 0 decrements. Any digit going 0→9 borrows from the next digit. All 0s → all 9s, with wrap=1.
- dir_s is sampled at each advance; a dir change mid-RUN applies from the next advance.
- clr_s=1: count_bcd←0, wrap←0. clr has priority over a simultaneous advance. clr does not affect the FSM or dividers.
- Scan:
  - The scan divider runs 0..DIV_SCAN-1 continuously, independent of mode.
  - Scan index 0..NUM_DIGITS-1 advances at each scan wrap and wraps to 0 after NUM_DIGITS-1.
  - fnd_com has bit[index]=0 and all other bits 1.
  - fnd_data is the decoded nibble[index].
  - If BLANK_LZ=1, index>0, and nibbles index..NUM_DIGITS-1 are all 0, then fnd_data=7'h7F.
- Nibble values above 9 are unreachable. The decoder nevertheless outputs blank for them.

## Timing
- Reset values:
  - count_bcd=0, wrap=0, FSM=STOP
  - dividers=0, scan index=0, synchronisers=0
  - fnd_com=all 1s, fnd_data=7'h7F
- After reset release, fnd_com/fnd_data show index 0 from the first clk edge.
- fnd_com and fnd_data are registered: they update one clk after a scan-index change or a count change.
- Input → effect latencies (count from the clk edge that first samples the input high):
  - step: count_bcd updates at the 3rd edge.
  - clr: count_bcd clears at the 3rd edge.
  - run: FSM enters RUN at the 3rd edge. The first RUN advance occurs DIV_COUNT cycles after entering RUN.
- wrap is high for exactly the one clk cycle in which count_bcd takes its wrapped value.
- rst is asserted asynchronously at any time, including mid-carry or mid-scan. All state returns immediately to reset values with no partial update.

## Structure
- Shared package fnd_pkg holds:
  - SEG_BLANK = 7'h7F
  - the BCD→seven-segment (active-low) decode function
  - FSM state typedef (ST_STOP, ST_RUN)
- Sub-module bcd_digit: one up/down BCD digit with en, dir, clr inputs and carry/borrow output. It is instantiated NUM_DIGITS times in a ripple chain; the top-level ANDs the carries to form wrap.
- Dividers, synchronisers, FSM and scan mux live in the top-level.

## Test plan
Bench parameters: NUM_DIGITS=4, DIV_COUNT=4, DIV_SCAN=2, BLANK_LZ=1.

- Reset mid-run at count 0x0123 → count_bcd=0, fnd_com=4'b1111, fnd_data=7'h7F while rst is high. After release, fnd_com=4'b1110 and fnd_data shows "0".
- run=1, dir=0 from 0x0998 → 0x0999 then 0x1000, each 4 clks apart. Carry ripples through three digits in a single cycle.
- run=1, dir=0 from 0x9999 → 0x0000 with wrap high exactly one cycle. Then dir=1 from 0x0000 → 0x9999 with wrap high one cycle.
- run=0, three step pulses from 0x0041 → 0x0044, each 3 clks after its edge. With run=1, step pulses leave the count unchanged apart from tick advances.
- clr asserted on the same cycle as a tick advance at 0x0507 → count_bcd=0x0000 and wrap=0.
- Count 0x0042, scan over 4 indices:
  - digits 2 and 3 get fnd_data=7'h7F
  - digit 1 shows "4" (7'b0011001)
  - digit 0 shows "2" (7'b0100100)
  - fnd_com cycles 1110→1101→1011→0111.
